// File: rtl/vga_timing_out.sv
// vga_timing_out: pixel-tick divider, h/v counters, sync/blank delay line and registered RGB output.
// Optional VGA_TEST_PATTERN_EN adds pattern_sel and eight vertical colour bars. Rev 1.0
`default_nettype none

module vga_timing_out #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter int PIPE_LAT  = 1,
  parameter int COLOR_W   = 12,
  parameter int SYNC_POL  = 0
) (
  input  logic               clk_100MHz,
  input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               video_on,
  output logic               p_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic POL   = SYNC_POL[0];
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_out: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_cfg
      $error("vga_timing_out: CLK_DIV must be >= 1 and PIPE_LAT within 0..7");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h;
  logic [9:0]       v;
  logic             hs_raw;
  logic             vs_raw;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div_cnt <= '0;
      h       <= '0;
      v       <= '0;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
      if (p_tick) begin
        if (h == 10'(H_TOTAL - 1)) begin
          h <= '0;
          v <= (v == 10'(V_TOTAL - 1)) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign p_tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign x           = h;
  assign y           = v;
  assign video_on    = (h < 10'(H_DISPLAY)) && (v < 10'(V_DISPLAY));
  assign frame_start = p_tick && (h == 10'd0) && (v == 10'd0);
  assign hs_raw      = (h >= HS_START) && (h <= HS_END);
  assign vs_raw      = (v >= VS_START) && (v <= VS_END);

`ifdef VGA_TEST_PATTERN_EN
  localparam int PW    = 6;
  localparam int BAR_W = (H_DISPLAY / 8 > 0) ? H_DISPLAY / 8 : 1;
  localparam int CH    = COLOR_W / 3;
  logic [2:0] bar_idx;
  assign bar_idx = 3'(h / 10'(BAR_W));

  function automatic logic [COLOR_W-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return COLOR_W'({{CH{m[2]}}, {CH{m[1]}}, {CH{m[0]}}});
  endfunction
`else
  localparam int PW = 3;
`endif

  logic [PW-1:0] stage_in;
  logic [PW-1:0] stage_out;

`ifdef VGA_TEST_PATTERN_EN
  assign stage_in = {bar_idx, hs_raw, vs_raw, video_on};
`else
  assign stage_in = {hs_raw, vs_raw, video_on};
`endif

  // Zero is the inactive/blank payload, so reset cannot release a stale sync pulse.
  generate
    if (PIPE_LAT > 0) begin : g_pipe
      logic [PW-1:0] pipe [PIPE_LAT];
      always_ff @(posedge clk_100MHz) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else if (p_tick) begin
          pipe[0] <= stage_in;
          for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign stage_out = pipe[PIPE_LAT-1];
    end else begin : g_nopipe
      assign stage_out = stage_in;
    end
  endgenerate

  logic [COLOR_W-1:0] color_src;
`ifdef VGA_TEST_PATTERN_EN
  assign color_src = pattern_sel ? bar_color(stage_out[5:3]) : rgb_in;
`else
  assign color_src = rgb_in;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      hsync <= ~POL;
      vsync <= ~POL;
      rgb   <= '0;
    end else if (p_tick) begin
      hsync <= stage_out[2] ? POL : ~POL;
      vsync <= stage_out[1] ? POL : ~POL;
      rgb   <= stage_out[0] ? color_src : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: two reduced-geometry instances (divided/active-low and undivided/active-high)
// checked every cycle against an arithmetic model of pixel position, sync and blanking.
`default_nettype none

module tb_vga_timing_out;

  localparam int HD = 16, HF = 2, HS = 3, HB = 3;
  localparam int VD = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int NCYC = 3600;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        ptick;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [11:0] rgb_in_a, rgb_in_b;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic        von_a, pt_a, fs_a, hs_a, vs_a;
  logic        von_b, pt_b, fs_b, hs_b, vs_b;
  logic [11:0] rgb_a, rgb_b;

  int checks = 0;
  int errors = 0;
  logic [11:0] tbl [64];

  always #5 clk = ~clk;

  vga_timing_out #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(4), .PIPE_LAT(1), .COLOR_W(12), .SYNC_POL(0)
  ) dut_a (
    .clk_100MHz(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .rgb_in(rgb_in_a), .x(x_a), .y(y_a), .video_on(von_a), .p_tick(pt_a),
    .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a)
  );

  vga_timing_out #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(1), .PIPE_LAT(3), .COLOR_W(12), .SYNC_POL(1)
  ) dut_b (
    .clk_100MHz(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .rgb_in(rgb_in_b), .x(x_b), .y(y_b), .video_on(von_b), .p_tick(pt_b),
    .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
  );

  // Colour the upstream generator holds for pixel number p since reset.
  function automatic logic [11:0] col(input int p);
    return (p < 0) ? 12'h000 : tbl[p % 64];
  endfunction

  // c = clock edges since reset released; every D edges the raster advances by one pixel.
  function automatic exp_t model(input int c, input int d, input int pl, input bit pol);
    exp_t e;
    int k, p, ph, pv;
    k       = c / d;
    e.x     = 10'(k % HT);
    e.y     = 10'((k / HT) % VT);
    e.von   = (k % HT < HD) && ((k / HT) % VT < VD);
    e.ptick = (c % d) == d - 1;
    e.fs    = e.ptick && (k % (HT * VT) == 0);
    p       = k - 1 - pl;
    if (p < 0) begin
      e.hs  = ~pol;
      e.vs  = ~pol;
      e.rgb = 12'h000;
    end else begin
      ph    = p % HT;
      pv    = (p / HT) % VT;
      e.hs  = (ph >= HD + HF && ph < HD + HF + HS) ? pol : ~pol;
      e.vs  = (pv >= VD + VF && pv < VD + VF + VS) ? pol : ~pol;
      e.rgb = (ph < HD && pv < VD) ? col(p) : 12'h000;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_dut(input string n, input exp_t e, input logic [9:0] ox, input logic [9:0] oy,
                         input logic ov, input logic op, input logic of, input logic oh,
                         input logic ovs, input logic [11:0] orgb);
    chk({n, ".x"}, 32'(ox), 32'(e.x));
    chk({n, ".y"}, 32'(oy), 32'(e.y));
    chk({n, ".video_on"}, 32'(ov), 32'(e.von));
    chk({n, ".p_tick"}, 32'(op), 32'(e.ptick));
    chk({n, ".frame_start"}, 32'(of), 32'(e.fs));
    chk({n, ".hsync"}, 32'(oh), 32'(e.hs));
    chk({n, ".vsync"}, 32'(ovs), 32'(e.vs));
    chk({n, ".rgb"}, 32'(orgb), 32'(e.rgb));
  endtask

  initial begin
    int c;
    int rc;
    exp_t ea, eb;
    for (int i = 0; i < 64; i++) tbl[i] = 12'($urandom_range(1, 4095));
    rc       = $urandom_range(1400, 2600);
    c        = 0;
    reset    = 1'b1;
    rgb_in_a = '0;
    rgb_in_b = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (reset) c = 0;
      else       c = c + 1;
      #1;
      reset    = (cyc < 2) || (cyc == rc);
      rgb_in_a = col(c / 4 - 1);
      rgb_in_b = col(c - 3);
      @(negedge clk);
      ea = model(c, 4, 1, 1'b0);
      eb = model(c, 1, 3, 1'b1);
      chk_dut("A", ea, x_a, y_a, von_a, pt_a, fs_a, hs_a, vs_a, rgb_a);
      chk_dut("B", eb, x_b, y_b, von_b, pt_b, fs_b, hs_b, vs_b, rgb_b);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
